morse_keyer_timing: RTL and testbench
=====================================

// Module: morse_keyer_timing
// PURPOSE
//   Upstream stage of morse_top. Turns one raw straight-key input into the four
//   single-cycle event strobes morse_top consumes: dot, dash, char_space and
//   word_space.
//   - Synchronises and debounces the key.
//   - Measures mark and gap lengths in Morse time units.
//   - Classifies each mark and gap against fixed unit thresholds.
// PARAMETERS
//   DEB_CYCLES   8    consecutive synced samples required to accept a key level change
//   UNIT_CYCLES  100  clk cycles per Morse time unit (dot length); >= 2
// PORTS
//   clk             in   1  system clock
//   rst             in   1  synchronous reset, active-high
//   key_in          in   1  raw asynchronous straight key, 1 = pressed
//   dot_out         out  1  1-cycle strobe: a dot was keyed
//   dash_out        out  1  1-cycle strobe: a dash was keyed
//   char_space_out  out  1  1-cycle strobe: inter-character gap detected
//   word_space_out  out  1  1-cycle strobe: inter-word gap detected
//   key_db          out  1  debounced key level (LED / debug)
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; all counters 0; synchroniser and debounce
//   registers hold 0 (released). A press aborted by rst emits nothing. A key held
//   through reset release is seen as a new press once debounced.
//   Input path:
//   - 2-flop synchroniser feeds the debouncer.
//   - key_db toggles only after the synced value differs from key_db for
//     DEB_CYCLES consecutive cycles.
//   - A glitch shorter than that is ignored.
//   - A clean press and release of N cycles yields a key_db pulse of exactly
//     N cycles.
//   Timing:
//   - Prescaler 0..UNIT_CYCLES-1 drives a 3-bit unit counter that saturates at 7.
//   - On every key_db edge, the prescaler and unit counter clear to 0.
//   - units = floor(cycles since last key_db edge / UNIT_CYCLES).
//   Constants: DASH_UNITS=2, CHAR_UNITS=2, WORD_UNITS=5.
//   FSM:
//   - IDLE: no pending symbols. On key_db rise -> MARK.
//   - MARK: on key_db fall -> GAP.
//     - Cycle after the fall: dot_out=1 if units<DASH_UNITS, else dash_out=1.
//     - Exactly one of the two fires per mark.
//   - GAP, key_db rise before CHAR_UNITS: -> MARK, no space strobe.
//   - GAP, units reaches CHAR_UNITS: char_space_out=1 for that one cycle; stay
//     in GAP.
//   - GAP, units reaches WORD_UNITS: word_space_out=1 for one cycle -> IDLE.
//     char_space has always fired first.
//   - GAP, key_db rise after char_space but before WORD_UNITS: -> MARK.
//   Boundaries:
//   - Mark held indefinitely saturates at 7 units; its release gives a dash.
//   - IDLE never emits spaces, however long the key stays idle.
//   - Key edges are at least DEB_CYCLES apart and strobes last 1 cycle, so no
//     two strobes ever assert in the same cycle.
//   - All outputs are registered.
// STRUCTURE
//   morse_pkg:
//   - state enum {IDLE, MARK, GAP}.
//   - DASH_UNITS, CHAR_UNITS, WORD_UNITS.
//   - UNIT_CNT_W = 3.
//   Sub-module morse_debounce (params DEB_CYCLES; ports clk, rst, key_in,
//   key_db): synchroniser plus debounce counter. The timing FSM and prescaler
//   live in morse_keyer_timing.
// TESTING  (DEB_CYCLES=4, UNIT_CYCLES=10; N = key_in high cycles, clean edges)
//   1. N=10, then idle:
//      - One dot_out, 1 cycle after the key_db fall.
//      - char_space_out 20 cycles after the fall.
//      - word_space_out 50 cycles after the fall, then IDLE.
//   2. N=19 -> dot_out; N=20 -> dash_out (threshold boundary).
//   3. 3-cycle glitch on key_in -> key_db stays 0; no strobes.
//   4. Dot (N=10), 15-cycle gap, dot (N=10) -> two dot_out strobes and no space
//      strobe between them.
//   5. N=200 (saturation) -> one dash_out.
//   6. rst high for 1 cycle mid-press (N=30 total) -> all outputs 0 and no
//      dot/dash after release.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and Morse timing constants for the straight-key front end.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int UNIT_CNT_W = 3;

    localparam logic [UNIT_CNT_W-1:0] DASH_UNITS = 3'd2;
    localparam logic [UNIT_CNT_W-1:0] CHAR_UNITS = 3'd2;
    localparam logic [UNIT_CNT_W-1:0] WORD_UNITS = 3'd5;
    localparam logic [UNIT_CNT_W-1:0] UNIT_MAX   = 3'd7;

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer.
// key_db follows the synced key only after DEB_CYCLES agreeing samples.
module morse_debounce #(
    parameter int DEB_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_db
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            key_db  <= 1'b0;
        end else begin
            sync_p0 <= key_in;
            // Stage boundary: synchronised level into the debounce counter.
            sync_p1 <= sync_p0;
            if (sync_p1 != key_db) begin
                if (cnt == CNT_LAST) begin
                    key_db <= sync_p1;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/morse_keyer_timing.sv
// Straight-key front end: debounces the key, times marks and gaps in Morse
// units and emits one-cycle dot / dash / char_space / word_space strobes.
module morse_keyer_timing
    import morse_pkg::*;
#(
    parameter int DEB_CYCLES  = 8,
    parameter int UNIT_CYCLES = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic dot_out,
    output logic dash_out,
    output logic char_space_out,
    output logic word_space_out,
    output logic key_db
);

    localparam int PRE_W = $clog2(UNIT_CYCLES);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(UNIT_CYCLES - 1);

    function automatic logic [UNIT_CNT_W-1:0] sat_inc(input logic [UNIT_CNT_W-1:0] v);
        return (v == UNIT_MAX) ? v : v + UNIT_CNT_W'(1);
    endfunction

    state_t                state;
    state_t                state_nxt;
    logic                  key_db_d;
    logic                  key_edge;
    logic [PRE_W-1:0]      pre;
    logic [PRE_W-1:0]      pre_eff;
    logic [PRE_W-1:0]      pre_nxt;
    logic [UNIT_CNT_W-1:0] units;
    logic [UNIT_CNT_W-1:0] units_eff;
    logic [UNIT_CNT_W-1:0] units_nxt;
    logic                  tick;
    logic                  char_hit;
    logic                  word_hit;
    logic                  dot_nxt;
    logic                  dash_nxt;
    logic                  char_nxt;
    logic                  word_nxt;

    morse_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .key_in(key_in),
        .key_db(key_db)
    );

    // The edge cycle itself counts as prescaler 0, so in any cycle the unit
    // register equals floor(cycles since the edge / UNIT_CYCLES).
    always_comb begin
        key_edge  = key_db ^ key_db_d;
        pre_eff   = key_edge ? '0 : pre;
        units_eff = key_edge ? '0 : units;
        tick      = (pre_eff == PRE_LAST);
        pre_nxt   = tick ? '0 : pre_eff + PRE_W'(1);
        units_nxt = tick ? sat_inc(units_eff) : units_eff;
        char_hit  = tick && (units_nxt == CHAR_UNITS);
        word_hit  = tick && (units_nxt == WORD_UNITS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_db_d <= 1'b0;
            pre      <= '0;
            units    <= '0;
        end else begin
            key_db_d <= key_db;
            pre      <= pre_nxt;
            units    <= units_nxt;
        end
    end

    // Mark length is classified from the pre-clear unit count in the fall cycle.
    always_comb begin
        state_nxt = state;
        dot_nxt   = 1'b0;
        dash_nxt  = 1'b0;
        char_nxt  = 1'b0;
        word_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (key_db) state_nxt = MARK;
            end
            MARK: begin
                if (!key_db) begin
                    state_nxt = GAP;
                    if (units >= DASH_UNITS) dash_nxt = 1'b1;
                    else                     dot_nxt  = 1'b1;
                end
            end
            GAP: begin
                if (key_db) begin
                    state_nxt = MARK;
                end else if (word_hit) begin
                    word_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (char_hit) begin
                    char_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            dot_out        <= 1'b0;
            dash_out       <= 1'b0;
            char_space_out <= 1'b0;
            word_space_out <= 1'b0;
        end else begin
            state          <= state_nxt;
            dot_out        <= dot_nxt;
            dash_out       <= dash_nxt;
            char_space_out <= char_nxt;
            word_space_out <= word_nxt;
        end
    end

endmodule

// File: tb/tb_morse_keyer_timing.sv
// Directed bench for morse_keyer_timing with DEB_CYCLES=4, UNIT_CYCLES=10.
module tb_morse_keyer_timing;

    logic clk = 1'b0;
    logic rst;
    logic key_in;
    logic dot_out;
    logic dash_out;
    logic char_space_out;
    logic word_space_out;
    logic key_db;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int dot_cnt = 0, dash_cnt = 0, char_cnt = 0, word_cnt = 0, rise_cnt = 0;
    int dot_cyc = 0, dash_cyc = 0, char_cyc = 0, word_cyc = 0;
    int rise_cyc = 0, fall_cyc = 0;
    logic kdb_prev = 1'b0;

    morse_keyer_timing #(
        .DEB_CYCLES (4),
        .UNIT_CYCLES(10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_in        (key_in),
        .dot_out       (dot_out),
        .dash_out      (dash_out),
        .char_space_out(char_space_out),
        .word_space_out(word_space_out),
        .key_db        (key_db)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling edge; tasks compare against it.
    always @(negedge clk) begin
        if (dot_out)        begin dot_cnt  = dot_cnt + 1;  dot_cyc  = cyc; end
        if (dash_out)       begin dash_cnt = dash_cnt + 1; dash_cyc = cyc; end
        if (char_space_out) begin char_cnt = char_cnt + 1; char_cyc = cyc; end
        if (word_space_out) begin word_cnt = word_cnt + 1; word_cyc = cyc; end
        if (key_db && !kdb_prev) begin rise_cnt = rise_cnt + 1; rise_cyc = cyc; end
        if (!key_db && kdb_prev) fall_cyc = cyc;
        kdb_prev = key_db;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(input int n);
        @(negedge clk);
        key_in = 1'b1;
        repeat (n) @(negedge clk);
        key_in = 1'b0;
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        key_in = 1'b0;
        idle(3);
        checks++; if (dot_out !== 1'b0) begin errors++; $display("FAIL reset_dot: got %b want 0", dot_out); end
        checks++; if (dash_out !== 1'b0) begin errors++; $display("FAIL reset_dash: got %b want 0", dash_out); end
        checks++; if (char_space_out !== 1'b0) begin errors++; $display("FAIL reset_char: got %b want 0", char_space_out); end
        checks++; if (word_space_out !== 1'b0) begin errors++; $display("FAIL reset_word: got %b want 0", word_space_out); end
        checks++; if (key_db !== 1'b0) begin errors++; $display("FAIL reset_key_db: got %b want 0", key_db); end
        @(negedge clk);
        rst = 1'b0;
        idle(5);
    endtask

    task automatic test_single_dot;
        int b_dot, b_dash, b_char, b_word, b_rise;
        b_dot = dot_cnt; b_dash = dash_cnt; b_char = char_cnt; b_word = word_cnt; b_rise = rise_cnt;
        press(10);
        idle(80);
        checks++; if (rise_cnt - b_rise != 1) begin errors++; $display("FAIL dot_rises: got %0d want 1", rise_cnt - b_rise); end
        checks++; if (fall_cyc - rise_cyc != 10) begin errors++; $display("FAIL dot_key_db_width: got %0d want 10", fall_cyc - rise_cyc); end
        checks++; if (dot_cnt - b_dot != 1) begin errors++; $display("FAIL dot_count: got %0d want 1", dot_cnt - b_dot); end
        checks++; if (dash_cnt - b_dash != 0) begin errors++; $display("FAIL dot_no_dash: got %0d want 0", dash_cnt - b_dash); end
        checks++; if (dot_cyc - fall_cyc != 1) begin errors++; $display("FAIL dot_latency: got %0d want 1", dot_cyc - fall_cyc); end
        checks++; if (char_cnt - b_char != 1) begin errors++; $display("FAIL dot_char_count: got %0d want 1", char_cnt - b_char); end
        checks++; if (char_cyc - fall_cyc != 20) begin errors++; $display("FAIL dot_char_latency: got %0d want 20", char_cyc - fall_cyc); end
        checks++; if (word_cnt - b_word != 1) begin errors++; $display("FAIL dot_word_count: got %0d want 1", word_cnt - b_word); end
        checks++; if (word_cyc - fall_cyc != 50) begin errors++; $display("FAIL dot_word_latency: got %0d want 50", word_cyc - fall_cyc); end
        idle(150);
        checks++; if (char_cnt - b_char != 1) begin errors++; $display("FAIL idle_char_quiet: got %0d want 1", char_cnt - b_char); end
        checks++; if (word_cnt - b_word != 1) begin errors++; $display("FAIL idle_word_quiet: got %0d want 1", word_cnt - b_word); end
    endtask

    task automatic test_threshold;
        int b_dot, b_dash;
        b_dot = dot_cnt; b_dash = dash_cnt;
        press(19);
        idle(80);
        checks++; if (dot_cnt - b_dot != 1) begin errors++; $display("FAIL n19_dot: got %0d want 1", dot_cnt - b_dot); end
        checks++; if (dash_cnt - b_dash != 0) begin errors++; $display("FAIL n19_dash: got %0d want 0", dash_cnt - b_dash); end
        b_dot = dot_cnt; b_dash = dash_cnt;
        press(20);
        idle(80);
        checks++; if (dash_cnt - b_dash != 1) begin errors++; $display("FAIL n20_dash: got %0d want 1", dash_cnt - b_dash); end
        checks++; if (dot_cnt - b_dot != 0) begin errors++; $display("FAIL n20_dot: got %0d want 0", dot_cnt - b_dot); end
        checks++; if (dash_cyc - fall_cyc != 1) begin errors++; $display("FAIL n20_dash_latency: got %0d want 1", dash_cyc - fall_cyc); end
    endtask

    task automatic test_glitch;
        int b_rise, b_sym;
        b_rise = rise_cnt;
        b_sym  = dot_cnt + dash_cnt + char_cnt + word_cnt;
        press(3);
        idle(40);
        checks++; if (rise_cnt - b_rise != 0) begin errors++; $display("FAIL glitch_key_db: got %0d rises want 0", rise_cnt - b_rise); end
        checks++; if (dot_cnt + dash_cnt + char_cnt + word_cnt - b_sym != 0) begin
            errors++; $display("FAIL glitch_strobes: got %0d want 0", dot_cnt + dash_cnt + char_cnt + word_cnt - b_sym);
        end
    endtask

    task automatic test_back_to_back;
        int b_dot, b_char, b_word, b_rise;
        b_dot = dot_cnt; b_char = char_cnt; b_word = word_cnt; b_rise = rise_cnt;
        @(negedge clk);
        key_in = 1'b1;
        repeat (10) @(negedge clk);
        key_in = 1'b0;
        repeat (15) @(negedge clk);
        key_in = 1'b1;
        repeat (10) @(negedge clk);
        key_in = 1'b0;
        idle(80);
        checks++; if (rise_cnt - b_rise != 2) begin errors++; $display("FAIL b2b_rises: got %0d want 2", rise_cnt - b_rise); end
        checks++; if (dot_cnt - b_dot != 2) begin errors++; $display("FAIL b2b_dots: got %0d want 2", dot_cnt - b_dot); end
        checks++; if (dot_cyc - fall_cyc != 1) begin errors++; $display("FAIL b2b_dot2_latency: got %0d want 1", dot_cyc - fall_cyc); end
        checks++; if (char_cnt - b_char != 1) begin errors++; $display("FAIL b2b_char_count: got %0d want 1", char_cnt - b_char); end
        checks++; if (char_cyc - fall_cyc != 20) begin errors++; $display("FAIL b2b_char_after_second: got %0d want 20", char_cyc - fall_cyc); end
        checks++; if (word_cnt - b_word != 1) begin errors++; $display("FAIL b2b_word_count: got %0d want 1", word_cnt - b_word); end
    endtask

    task automatic test_saturation;
        int b_dot, b_dash;
        b_dot = dot_cnt; b_dash = dash_cnt;
        press(200);
        idle(80);
        checks++; if (dash_cnt - b_dash != 1) begin errors++; $display("FAIL sat_dash: got %0d want 1", dash_cnt - b_dash); end
        checks++; if (dot_cnt - b_dot != 0) begin errors++; $display("FAIL sat_dot: got %0d want 0", dot_cnt - b_dot); end
        checks++; if (dash_cyc - fall_cyc != 1) begin errors++; $display("FAIL sat_dash_latency: got %0d want 1", dash_cyc - fall_cyc); end
    endtask

    task automatic test_reset_mid_press;
        int b_dot, b_dash, b_char, b_word, b_rise;
        b_dot = dot_cnt; b_dash = dash_cnt; b_char = char_cnt; b_word = word_cnt; b_rise = rise_cnt;
        @(negedge clk);
        key_in = 1'b1;
        repeat (27) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (key_db !== 1'b0) begin errors++; $display("FAIL rstmid_key_db: got %b want 0", key_db); end
        checks++; if ({dot_out, dash_out, char_space_out, word_space_out} !== 4'b0000) begin
            errors++; $display("FAIL rstmid_strobes: got %b want 0000", {dot_out, dash_out, char_space_out, word_space_out});
        end
        repeat (2) @(negedge clk);
        key_in = 1'b0;
        idle(80);
        checks++; if (rise_cnt - b_rise != 1) begin errors++; $display("FAIL rstmid_rises: got %0d want 1", rise_cnt - b_rise); end
        checks++; if (dot_cnt + dash_cnt - b_dot - b_dash != 0) begin
            errors++; $display("FAIL rstmid_symbols: got %0d want 0", dot_cnt + dash_cnt - b_dot - b_dash);
        end
        checks++; if (char_cnt + word_cnt - b_char - b_word != 0) begin
            errors++; $display("FAIL rstmid_spaces: got %0d want 0", char_cnt + word_cnt - b_char - b_word);
        end
    endtask

    initial begin
        rst    = 1'b1;
        key_in = 1'b0;
        test_reset;
        test_single_dot;
        test_threshold;
        test_glitch;
        test_back_to_back;
        test_saturation;
        test_reset_mid_press;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
